instruction_fetch_unit: RTL and testbench
=========================================

Name: instruction_fetch_unit

Overview:
- Fetch-side master for the synchronous instruction memory.
- Drives a 4-byte-aligned PC to the memory and captures each returned word one cycle after the memory samples the PC.
- Buffers returned words and presents them to decode over a valid/ready handshake.
- Performs early jump redirection (J opcode) and accepts late redirects from execute, squashing wrong-path fetches.

Parameters:
- ADDR_WIDTH, 4, PC/address width in bits; PC arithmetic is mod 2^ADDR_WIDTH.
- DATA_WIDTH, 32, instruction width.
- DEPTH, 2, output buffer entries (2 is the minimum for 1 instr/cycle throughput).
- RESET_PC, 0, first fetch address.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  synchronous active-low reset.
- mem_pc  out  ADDR_WIDTH  address to instruction memory; registered.
- mem_instruction  in  DATA_WIDTH  memory read data; valid the cycle after the memory samples mem_pc.
- out_valid  out  1  buffer head valid.
- out_instr  out  DATA_WIDTH  instruction at buffer head.
- out_pc  out  ADDR_WIDTH  PC of out_instr.
- out_ready  in  1  decode accepts head; transfer occurs when out_valid && out_ready.
- redirect_valid  in  1  execute-stage redirect (branch/jump resolved).
- redirect_pc  in  ADDR_WIDTH  redirect target; bits [1:0] are ignored and treated as 0.

Behaviour:
- Reset (rst_n=0 at an edge): pc_q=RESET_PC, mem_pc=RESET_PC, buffer empty, out_valid=0, out_instr=0, out_pc=0, inflight=0, epoch=0.
- Issue: in a cycle where rst_n=1 and credit is available, the current pc_q is the request. The memory captures it at that cycle's end. Set inflight=1 with the tagged PC and epoch. Advance pc_q to pc_q+4, wrapping mod 2^ADDR_WIDTH (12 -> 0 at width 4).
- Credit rule: issue if count + inflight - (out_valid && out_ready) < DEPTH.
- Response: the cycle after an issue, mem_instruction is valid. At that cycle's end it is written into the buffer with its PC, unless killed. The first rst_n-high cycle is cycle 0 (issue of RESET_PC), so out_valid first asserts in cycle 2.
- Throughput: sustained 1 instr/cycle with out_ready held at 1.
- Early jump: a non-killed response with instr[31:26]==J_OPCODE is still enqueued.
  - Same edge: pc_q <= {instr[ADDR_WIDTH-1:2],2'b00}.
  - Any request issued in the response cycle, which is the sequential wrong path, is killed.
- Redirect (redirect_valid=1 at an edge):
  - Buffer flushed (count=0, out_valid=0 next cycle).
  - In-flight request killed via epoch toggle.
  - pc_q <= redirect_pc & ~3; no issue in the redirect cycle takes effect.
  - Fetch resumes from the new PC in the next cycle.
- Kill: a response whose epoch differs from the current epoch is discarded; it is never enqueued and never triggers a jump.
- Simultaneous events:
  - redirect + early-jump response in the same cycle: redirect wins.
  - redirect + handshake in the same cycle: the transfer completes (decode consumed it), then the flush takes effect.
  - enqueue + dequeue in the same cycle: count is unchanged.
- Buffer full: the credit rule guarantees no enqueue when full; an overflow is a design error (assertion).
- out_instr/out_pc hold their values while out_valid=1 and out_ready=0.
- Reset mid-operation: all state returns to reset values next cycle, and any in-flight response is ignored.
- Memory with no reset or no enable: responses are qualified only by the inflight flag; mem_instruction is ignored when inflight=0.

Decomposition:
- Package fetch_pkg: J_OPCODE=6'b000010, OPCODE_MSB=31, OPCODE_LSB=26, PC_STEP=4.
- Sub-module fetch_buffer: synchronous FIFO parameterised by DEPTH and entry width (DATA_WIDTH+ADDR_WIDTH), with flush input, count output, and full/empty flags.

Test Plan:
- Reset then out_ready=1, memory loaded with {0:08000004, 4:02508020, 8:02118020, 12:02328020}:
  - out_valid first asserts in cycle 2 with (pc0, 08000004).
  - Then (4, 02508020), (8, 02118020), (12, 02328020).
  - No wrong-path entry between pc0 and pc4.
- Wrap: continue the stream past PC 12 -> next transfer is pc0 (wrap), followed by the jump to 4 again; steady 1/cycle.
- Backpressure: hold out_ready=0 for 5 cycles at any point:
  - count reaches 2; mem_pc stops advancing.
  - out_instr is stable.
  - On release, the sequence resumes with no loss or duplication.
- Redirect: redirect_valid=1, redirect_pc=4'b1001 mid-stream:
  - Buffer empties next cycle; in-flight word is discarded.
  - Next transfer is (8, 02118020).
- Redirect + jump response: redirect_pc=12 in the same cycle the J word responds -> next transfer is pc12, not pc4.
- Reset mid-stream: assert rst_n=0 for one cycle while count=2 and inflight=1:
  - out_valid=0 next cycle.
  - Restart from pc0, with the first transfer 2 cycles after release.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared constants for the instruction fetch slice: jump opcode decode and PC stepping.
package fetch_pkg;

  localparam logic [5:0] J_OPCODE   = 6'b000010;
  localparam int         OPCODE_MSB = 31;
  localparam int         OPCODE_LSB = 26;
  localparam int         PC_STEP    = 4;

  function automatic logic is_jump(input logic [OPCODE_MSB-OPCODE_LSB:0] opcode);
    return opcode == J_OPCODE;
  endfunction

endpackage

// File: rtl/fetch_buffer.sv
// Small synchronous FIFO holding fetched {pc, instruction} entries for decode.
module fetch_buffer
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int WIDTH = 36,
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] storage [DEPTH];
  logic [IW-1:0]    rd_ptr;
  logic [IW-1:0]    wr_ptr;
  logic             do_push;
  logic             do_pop;

  function automatic logic [IW-1:0] bump(input logic [IW-1:0] p);
    return (p == IW'(DEPTH - 1)) ? '0 : p + IW'(1);
  endfunction

  // A push into a full buffer is only legal when the head leaves in the same cycle.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        storage[i] <= '0;
      end
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        storage[wr_ptr] <= wdata;
        wr_ptr          <= bump(wr_ptr);
      end
      if (do_pop) begin
        rd_ptr <= bump(rd_ptr);
      end
      if (do_push && !do_pop) begin
        count <= count + CW'(1);
      end else if (!do_push && do_pop) begin
        count <= count - CW'(1);
      end
    end
  end

  assign rdata = storage[rd_ptr];
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch master: issues PCs to a synchronous instruction memory, buffers responses for decode,
// follows J instructions early and honours execute-stage redirects.
module instruction_fetch_unit
  import fetch_pkg::*;
#(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 2,
  parameter int RESET_PC   = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic [ADDR_WIDTH-1:0] mem_pc,
  input  logic [DATA_WIDTH-1:0] mem_instruction,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_instr,
  output logic [ADDR_WIDTH-1:0] out_pc,
  input  logic                  out_ready,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int EW = DATA_WIDTH + ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(3);

  logic [ADDR_WIDTH-1:0] pc_q;
  logic [ADDR_WIDTH-1:0] pc_next;
  logic [ADDR_WIDTH-1:0] infl_pc;
  logic [ADDR_WIDTH-1:0] jump_target;
  logic [ADDR_WIDTH-1:0] redirect_aligned;
  logic                  inflight;
  logic                  infl_epoch;
  logic                  epoch;
  logic                  resp_live;
  logic                  enq;
  logic                  deq;
  logic                  jump;
  logic                  credit;
  logic                  issue;
  logic [CW-1:0]         count;
  logic                  full;
  logic                  empty;
  logic [EW-1:0]         head;
  logic [CW:0]           occupancy;
  logic [CW:0]           limit;

  assign deq              = out_valid && out_ready;
  assign resp_live        = inflight && (infl_epoch == epoch);
  assign enq              = resp_live && !redirect_valid;
  assign jump             = enq && is_jump(mem_instruction[OPCODE_MSB:OPCODE_LSB]);
  assign jump_target      = mem_instruction[ADDR_WIDTH-1:0] & ALIGN_MASK;
  assign redirect_aligned = redirect_pc & ALIGN_MASK;

  // Credit counts the in-flight word as already occupying a slot, so the buffer can never overflow.
  assign occupancy = {1'b0, count} + (CW + 1)'(inflight);
  assign limit     = (CW + 1)'(DEPTH) + (CW + 1)'(deq);
  assign credit    = occupancy < limit;

  // The sequential fetch in a jump-response cycle is wrong-path, so it is simply not issued.
  assign issue = credit && !redirect_valid && !jump;

  always_comb begin
    pc_next = pc_q;
    if (redirect_valid) begin
      pc_next = redirect_aligned;
    end else if (jump) begin
      pc_next = jump_target;
    end else if (issue) begin
      pc_next = pc_q + ADDR_WIDTH'(PC_STEP);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q       <= ADDR_WIDTH'(RESET_PC);
      mem_pc     <= ADDR_WIDTH'(RESET_PC);
      inflight   <= 1'b0;
      infl_pc    <= '0;
      infl_epoch <= 1'b0;
      epoch      <= 1'b0;
    end else begin
      pc_q     <= pc_next;
      mem_pc   <= pc_next;
      inflight <= issue;
      if (issue) begin
        infl_pc    <= pc_q;
        infl_epoch <= epoch;
      end
      if (redirect_valid) begin
        epoch <= ~epoch;
      end
    end
  end

  fetch_buffer #(
    .DEPTH (DEPTH),
    .WIDTH (EW)
  ) u_buf (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (redirect_valid),
    .push  (enq),
    .pop   (deq),
    .wdata ({infl_pc, mem_instruction}),
    .rdata (head),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  assign out_valid = !empty;
  assign out_instr = head[DATA_WIDTH-1:0];
  assign out_pc    = head[EW-1:DATA_WIDTH];

  overflow_check: assert property (@(posedge clk) disable iff (!rst_n || redirect_valid)
    !(enq && full && !deq));

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench: directed scenarios plus randomized traffic against a program-order model.
module tb_instruction_fetch_unit;

  localparam int AW    = 4;
  localparam int DW    = 32;
  localparam int DEPTH = 2;
  localparam logic [5:0] J_OP = 6'b000010;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [AW-1:0] mem_pc;
  logic [DW-1:0] mem_instruction = '0;
  logic          out_valid;
  logic [DW-1:0] out_instr;
  logic [AW-1:0] out_pc;
  logic          out_ready = 1'b0;
  logic          redirect_valid = 1'b0;
  logic [AW-1:0] redirect_pc = '0;

  logic [31:0] mem [4];

  int          n_checks = 0;
  int          n_fail = 0;
  logic [3:0]  exp_pc = 4'd0;
  int          stall = 0;
  logic        prev_hold = 1'b0;
  logic [3:0]  prev_pc = '0;
  logic [31:0] prev_instr = '0;
  logic        obs_valid;
  logic [3:0]  obs_pc;
  logic [3:0]  obs_mem_pc;
  logic [31:0] obs_instr;
  logic [3:0]  saved_mem_pc;

  instruction_fetch_unit #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .DEPTH      (DEPTH),
    .RESET_PC   (0)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .mem_pc          (mem_pc),
    .mem_instruction (mem_instruction),
    .out_valid       (out_valid),
    .out_instr       (out_instr),
    .out_pc          (out_pc),
    .out_ready       (out_ready),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc)
  );

  always #5 clk = ~clk;

  // Synchronous instruction memory: samples the address every edge, data valid next cycle.
  always @(posedge clk) mem_instruction <= mem[mem_pc[3:2]];

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Program order: a J word continues at its aligned target, anything else falls through by 4.
  function automatic logic [3:0] next_pc(input logic [3:0] p);
    logic [31:0] w;
    w = mem[p[3:2]];
    if (w[31:26] == J_OP) return {w[3:2], 2'b00};
    return p + 4'd4;
  endfunction

  task automatic applyStimulus(input logic rst_v, input logic ready_v, input logic redir_v,
                               input logic [3:0] rpc);
    @(negedge clk);
    obs_valid  = out_valid;
    obs_pc     = out_pc;
    obs_instr  = out_instr;
    obs_mem_pc = mem_pc;
    if (prev_hold) begin
      checkOutput("hold_valid", 32'(out_valid), 32'd1);
      checkOutput("hold_pc", 32'(out_pc), 32'(prev_pc));
      checkOutput("hold_instr", out_instr, prev_instr);
    end
    if (out_valid) stall = 0;
    else stall++;
    if (stall > 6) begin
      checkOutput("progress", 32'(stall), 32'd6);
      stall = 0;
    end
    rst_n          = rst_v;
    out_ready      = ready_v;
    redirect_valid = redir_v;
    redirect_pc    = rpc;
    if (rst_v && out_valid && ready_v) begin
      checkOutput("xfer_pc", 32'(out_pc), 32'(exp_pc));
      checkOutput("xfer_instr", out_instr, mem[exp_pc[3:2]]);
      exp_pc = next_pc(exp_pc);
    end
    if (!rst_v) begin
      exp_pc = 4'd0;
      stall  = 0;
    end else if (redir_v) begin
      exp_pc = rpc & 4'hC;
      stall  = 0;
    end
    prev_hold  = rst_v && out_valid && !ready_v && !redir_v;
    prev_pc    = out_pc;
    prev_instr = out_instr;
  endtask

  task automatic waitValid();
    int n;
    n = 0;
    while (!obs_valid && n < 8) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 4'd0);
      n++;
    end
    if (!obs_valid) checkOutput("wait_valid_timeout", 32'(obs_valid), 32'd1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: got no end expected end");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    mem[0] = 32'h08000004;
    mem[1] = 32'h02508020;
    mem[2] = 32'h02118020;
    mem[3] = 32'h02328020;

    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_valid", 32'(out_valid), 32'd0);
    checkOutput("reset_instr", out_instr, 32'd0);
    checkOutput("reset_out_pc", 32'(out_pc), 32'd0);
    checkOutput("reset_mem_pc", 32'(mem_pc), 32'd0);

    applyStimulus(1'b1, 1'b1, 1'b0, 4'd0);
    applyStimulus(1'b1, 1'b1, 1'b0, 4'd0);
    checkOutput("cycle1_valid", 32'(obs_valid), 32'd0);
    applyStimulus(1'b1, 1'b1, 1'b0, 4'd0);
    checkOutput("cycle2_valid", 32'(obs_valid), 32'd1);
    checkOutput("first_pc", 32'(obs_pc), 32'd0);
    checkOutput("first_instr", obs_instr, 32'h08000004);

    repeat (16) applyStimulus(1'b1, 1'b1, 1'b0, 4'd0);

    // Backpressure: hold decode off for five cycles.
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 4'd0);
      if (i == 2) saved_mem_pc = obs_mem_pc;
      if (i > 2) checkOutput("bp_mem_pc_stall", 32'(obs_mem_pc), 32'(saved_mem_pc));
      if (i == 4) checkOutput("bp_count", 32'(dut.count), 32'd2);
    end
    repeat (6) applyStimulus(1'b1, 1'b1, 1'b0, 4'd0);

    // Redirect to an unaligned target.
    applyStimulus(1'b1, 1'b1, 1'b1, 4'b1001);
    applyStimulus(1'b1, 1'b1, 1'b0, 4'd0);
    checkOutput("redirect_flush", 32'(obs_valid), 32'd0);
    waitValid();
    checkOutput("redirect_pc", 32'(obs_pc), 32'd8);
    checkOutput("redirect_instr", obs_instr, 32'h02118020);
    repeat (4) applyStimulus(1'b1, 1'b1, 1'b0, 4'd0);

    // Redirect lands in the same cycle the J word at 0 responds.
    applyStimulus(1'b1, 1'b1, 1'b1, 4'd0);
    applyStimulus(1'b1, 1'b1, 1'b0, 4'd0);
    applyStimulus(1'b1, 1'b1, 1'b1, 4'd12);
    applyStimulus(1'b1, 1'b0, 1'b0, 4'd0);
    waitValid();
    checkOutput("redir_vs_jump_pc", 32'(obs_pc), 32'd12);
    repeat (4) applyStimulus(1'b1, 1'b1, 1'b0, 4'd0);

    // Reset with a full buffer.
    repeat (3) applyStimulus(1'b1, 1'b0, 1'b0, 4'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 4'd0);
    applyStimulus(1'b1, 1'b1, 1'b0, 4'd0);
    checkOutput("midreset_flush", 32'(obs_valid), 32'd0);
    applyStimulus(1'b1, 1'b1, 1'b0, 4'd0);
    checkOutput("restart_c1_valid", 32'(obs_valid), 32'd0);
    applyStimulus(1'b1, 1'b1, 1'b0, 4'd0);
    checkOutput("restart_c2_valid", 32'(obs_valid), 32'd1);
    checkOutput("restart_pc", 32'(obs_pc), 32'd0);

    // Randomized traffic over freshly randomized programs.
    for (int r = 0; r < 4; r++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 4'd0);
      for (int k = 0; k < 4; k++) begin
        logic [31:0] w;
        w = $urandom;
        if ($urandom_range(0, 2) == 0) w[31:26] = J_OP;
        else if (w[31:26] == J_OP) w[31:26] = 6'd0;
        mem[k] = w;
      end
      for (int c = 0; c < 150; c++) begin
        int rv;
        rv = $urandom_range(0, 99);
        if (rv < 2) applyStimulus(1'b0, 1'b0, 1'b0, 4'd0);
        else if (rv < 8) applyStimulus(1'b1, 1'($urandom_range(0, 1)), 1'b1, 4'($urandom));
        else applyStimulus(1'b1, 1'($urandom_range(0, 3) != 0), 1'b0, 4'd0);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
